butterfly_r2_pipe: RTL and testbench
====================================

# butterfly_r2_pipe

Parametrised, fully pipelined radix-2 FFT butterfly with valid/ready flow control, selectable DIT/DIF per sample, optional divide-by-2 scaling, and round-and-saturate output. It is the datapath core of each FFT stage and sits between the stage's input reorder buffer and its output buffer. It supersedes the fixed 32-bit, two-cycle, handshake-free butterfly. It accepts one butterfly per cycle.

## Interface
- DATA_WIDTH, 16: signed two's-complement width of each real/imag data component, in and out.
- TW_WIDTH, 16: signed twiddle component width. Format is Q2.(TW_WIDTH-2), so 1.0 = 2^(TW_WIDTH-2) (16384 at default).
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- in_valid_i  in  1  input beat valid.
- in_ready_o  out  1  block can accept a beat this cycle.
- mode_dif_i  in  1  0 = DIT, 1 = DIF. Sampled with the beat.
- scale_i  in  1  1 = halve both outputs. Sampled with the beat.
- in1_r_i, in1_i_i, in2_r_i, in2_i_i  in  DATA_WIDTH each  input operands.
- w_r_i, w_i_i  in  TW_WIDTH each  twiddle.
- out_valid_o  out  1  output beat valid.
- out_ready_i  in  1  downstream accepts the beat.
- out1_r_o, out1_i_o, out2_r_o, out2_i_o  out  DATA_WIDTH each  results.
- ovf_o  out  1  at least one of the four outputs saturated on this beat. Qualified by out_valid_o.

## Operation
- Transfer rules:
  - Input transfer = in_valid_i & in_ready_o.
  - Output transfer = out_valid_o & out_ready_i.
- DIT: p = in2·w; out1 = in1 + p; out2 = in1 − p.
- DIF: out1 = in1 + in2; out2 = (in1 − in2)·w.
- Complex product:
  - Re = a_r·w_r − a_i·w_i; Im = a_r·w_i + a_i·w_r.
  - Computed at full precision: DATA_WIDTH+TW_WIDTH+1 bits, plus 1 extra bit in DIF for the pre-subtract.
  - Rounded once: add 2^(TW_WIDTH-3), then arithmetic shift right by TW_WIDTH-2 (round half toward +inf).
- Add/sub is performed at DATA_WIDTH+2 bits. Nothing is truncated before the final saturation.
- Scale: if scale_i, each result gets +1 added, then an arithmetic shift right by 1.
- Saturate each component to [−2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)−1]. ovf_o = OR of the four clip events.
- mode_dif_i and scale_i travel down the pipe with their beat. Mixed modes on consecutive beats are legal.

## Timing
- Four register stages:
  - S1: input capture; DIF pre-add/sub.
  - S2: four real products.
  - S3: product combine and round.
  - S4: add/sub, scale, saturate, output registers.
- Latency: 4 cycles from input transfer to out_valid_o, with out_ready_i held at 1.
- Global advance:
  - adv = ~out_valid_o | out_ready_i, and in_ready_o = adv.
  - When adv = 0 every stage holds, including its valid bit.
  - Outputs and ovf_o stay stable while out_valid_o=1 and out_ready_i=0.
- Throughput is 1 beat/cycle while out_ready_i=1. Per-stage valid bits carry bubbles down the pipe.
- Simultaneous output transfer and new input in the same cycle is legal, with no bubble inserted.
- Reset values:
  - Synchronous rst clears all stage valid bits.
  - out_valid_o=0, ovf_o=0, and all data outputs = 0.
  - in_ready_o=1 in the first cycle after reset.
- Reset mid-operation discards every in-flight beat. No partial beat is ever emitted.
- Data registers need no reset except the output registers, which do.

## Structure
- Shared package fft_pkg holds:
  - TW_ONE(TW_WIDTH) constant function.
  - Rounding-shift function.
  - Saturate function, returning value and clip flag.
  - DIT/DIF mode encoding localparams.
- Sub-module cmul_pipe holds S2–S3: a 2-stage pipelined complex multiply and round, with an enable input driven by adv. The butterfly wraps it with S1 and S4 plus the valid chain.

## Test plan
- DIT, w=(16384,0), in1=(1000,200), in2=(300,−100), scale=0 -> out1=(1300,100), out2=(700,300), ovf_o=0, 4 cycles after accept.
- DIT, w=(0,−16384), same inputs -> out1=(900,−100), out2=(1100,500). Repeat with scale=1 -> out1=(450,−50), out2=(550,250).
- DIF, w=(0,−16384), same inputs -> out1=(1300,100), out2=(300,−700). Alternate DIT/DIF beat-by-beat; each beat's result matches its own mode.
- Rounding: DIT, w=(8192,0), in1=(0,0), in2=(3,−3) -> out1=(2,−1), out2=(−2,1).
- Saturation: in1=(32767,−32768), in2=(32767,−32768), w=(16384,0), scale=0 -> out1=(32767,−32768), out2=(0,0), ovf_o=1. Same with scale=1 -> out1=(32767,−32768), ovf_o=0.
- Flow control:
  - Stream 20 beats with random out_ready_i -> in_ready_o tracks adv, held outputs never change, no beat is lost or duplicated, order is preserved.
  - Assert rst with 3 beats in flight -> out_valid_o=0 the next cycle and none of those beats ever appear.

Source files
------------

// File: rtl/fft_pkg.sv
// ---------------------------------------------------------------------------
// fft_pkg
// Shared definitions for the FFT stage datapath.
//   MODE_DIT / MODE_DIF : encoding of the per-beat butterfly mode bit.
//   satResult_t         : saturated value plus a flag telling whether it clipped.
//   TW_ONE(twWidth)     : integer value of 1.0 in the Q2.(twWidth-2) twiddle format.
//   roundShift(x, sh)   : add half an LSB, then arithmetic shift right by sh
//                         (round half toward +inf).
//   saturate(x, width)  : clip x into the signed range of 'width' bits.
// The helpers work on 64-bit signed values so that any parameterisation of
// the butterfly can share them; callers slice the result back down.
// ---------------------------------------------------------------------------
package fft_pkg;

   localparam logic MODE_DIT = 1'b0;
   localparam logic MODE_DIF = 1'b1;

   typedef struct packed {
      logic signed [63:0] value;
      logic               clip;
   } satResult_t;

   function automatic int TW_ONE(input int twWidth);
      return 1 << (twWidth - 2);
   endfunction

   function automatic logic signed [63:0] roundShift(input logic signed [63:0] x,
                                                     input int                 shift);
      logic signed [63:0] half;
      half = 64'sd1 <<< (shift - 1);
      return (x + half) >>> shift;
   endfunction

   function automatic satResult_t saturate(input logic signed [63:0] x,
                                           input int                 width);
      satResult_t         r;
      logic signed [63:0] hi;
      logic signed [63:0] lo;
      hi = (64'sd1 <<< (width - 1)) - 64'sd1;
      lo = -hi - 64'sd1;
      r.value = x;
      r.clip  = 1'b0;
      if (x > hi) begin
         r.value = hi;
         r.clip  = 1'b1;
      end else if (x < lo) begin
         r.value = lo;
         r.clip  = 1'b1;
      end
      return r;
   endfunction

endpackage

// File: rtl/cmul_pipe.sv
// ---------------------------------------------------------------------------
// cmul_pipe
// Two-stage pipelined complex multiply with a single rounding step.
//   clk          : rising-edge clock
//   enable       : pipeline advance; both stages hold when low
//   aRe, aIm     : signed operand, A_WIDTH bits each
//   wRe, wIm     : signed twiddle, Q2.(TW_WIDTH-2)
//   pRe, pIm     : rounded product, A_WIDTH+3 bits each (no bits dropped
//                  above the rounding point)
// Stage 1 registers the four real products, stage 2 combines and rounds.
// ---------------------------------------------------------------------------
module cmul_pipe
   import fft_pkg::*;
#(
   parameter int A_WIDTH  = 17,
   parameter int TW_WIDTH = 16
) (
   input  logic                         clk,
   input  logic                         enable,
   input  logic signed [A_WIDTH-1:0]    aRe,
   input  logic signed [A_WIDTH-1:0]    aIm,
   input  logic signed [TW_WIDTH-1:0]   wRe,
   input  logic signed [TW_WIDTH-1:0]   wIm,
   output logic signed [A_WIDTH+2:0]    pRe,
   output logic signed [A_WIDTH+2:0]    pIm
);

   localparam int PROD_W = A_WIDTH + TW_WIDTH;
   localparam int SUM_W  = PROD_W + 1;
   localparam int OUT_W  = A_WIDTH + 3;

   logic signed [PROD_W-1:0] prodRR;
   logic signed [PROD_W-1:0] prodII;
   logic signed [PROD_W-1:0] prodRI;
   logic signed [PROD_W-1:0] prodIR;
   logic signed [SUM_W-1:0]  sumRe;
   logic signed [SUM_W-1:0]  sumIm;
   logic signed [63:0]       roundRe;
   logic signed [63:0]       roundIm;

   // Four full-precision real products; operands are widened first so the
   // multiply is exact and signed.
   always_ff @(posedge clk) begin
      if (enable) begin
         prodRR <= PROD_W'(aRe) * PROD_W'(wRe);
         prodII <= PROD_W'(aIm) * PROD_W'(wIm);
         prodRI <= PROD_W'(aRe) * PROD_W'(wIm);
         prodIR <= PROD_W'(aIm) * PROD_W'(wRe);
      end
   end

   // Combine into real/imag parts with one growth bit, then round away the
   // twiddle fraction bits exactly once.
   always_comb begin
      sumRe   = SUM_W'(prodRR) - SUM_W'(prodII);
      sumIm   = SUM_W'(prodRI) + SUM_W'(prodIR);
      roundRe = roundShift(64'(sumRe), TW_WIDTH - 2);
      roundIm = roundShift(64'(sumIm), TW_WIDTH - 2);
   end

   // Rounded product register.
   always_ff @(posedge clk) begin
      if (enable) begin
         pRe <= roundRe[OUT_W-1:0];
         pIm <= roundIm[OUT_W-1:0];
      end
   end

endmodule

// File: rtl/butterfly_r2_pipe.sv
// ---------------------------------------------------------------------------
// butterfly_r2_pipe
// Fully pipelined radix-2 butterfly, one beat per cycle, DIT or DIF per beat.
//   clk, rst                   : clock, synchronous active-high reset
//   in_valid_i / in_ready_o    : input handshake
//   mode_dif_i                 : 0 = DIT (out = in1 +/- in2*w),
//                                1 = DIF (out1 = in1+in2, out2 = (in1-in2)*w)
//   scale_i                    : halve both outputs (round half toward +inf)
//   in1_*, in2_*               : complex inputs, DATA_WIDTH each
//   w_r_i, w_i_i               : twiddle, Q2.(TW_WIDTH-2)
//   out_valid_o / out_ready_i  : output handshake
//   out1_*, out2_*             : saturated results, DATA_WIDTH each
//   ovf_o                      : some component of this beat clipped
// Stages: S1 capture/pre-add, S2-S3 in cmul_pipe, S4 add/scale/saturate.
// All stages advance together whenever the output register is free or
// being drained, so backpressure simply freezes the whole pipe.
// ---------------------------------------------------------------------------
module butterfly_r2_pipe
   import fft_pkg::*;
#(
   parameter int DATA_WIDTH = 16,
   parameter int TW_WIDTH   = 16
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          in_valid_i,
   output logic                          in_ready_o,
   input  logic                          mode_dif_i,
   input  logic                          scale_i,
   input  logic signed [DATA_WIDTH-1:0]  in1_r_i,
   input  logic signed [DATA_WIDTH-1:0]  in1_i_i,
   input  logic signed [DATA_WIDTH-1:0]  in2_r_i,
   input  logic signed [DATA_WIDTH-1:0]  in2_i_i,
   input  logic signed [TW_WIDTH-1:0]    w_r_i,
   input  logic signed [TW_WIDTH-1:0]    w_i_i,
   output logic                          out_valid_o,
   input  logic                          out_ready_i,
   output logic signed [DATA_WIDTH-1:0]  out1_r_o,
   output logic signed [DATA_WIDTH-1:0]  out1_i_o,
   output logic signed [DATA_WIDTH-1:0]  out2_r_o,
   output logic signed [DATA_WIDTH-1:0]  out2_i_o,
   output logic                          ovf_o
);

   localparam int A_W   = DATA_WIDTH + 1;
   localparam int SUM_W = A_W + 3;
   localparam logic signed [SUM_W-1:0] SUM_ONE = SUM_W'(1);

   logic                        adv;
   logic                        validS1, validS2, validS3;
   logic                        modeS1, modeS2, modeS3;
   logic                        scaleS1, scaleS2, scaleS3;
   logic signed [A_W-1:0]       aReS1, aImS1;
   logic signed [A_W-1:0]       bReS1, bImS1, bReS2, bImS2, bReS3, bImS3;
   logic signed [TW_WIDTH-1:0]  wReS1, wImS1;
   logic signed [SUM_W-1:0]     pRe, pIm;
   logic signed [SUM_W-1:0]     rawRes [4];
   logic signed [SUM_W-1:0]     scaledRes [4];
   satResult_t                  satRes [4];

   // The whole pipe moves when the output slot is empty or being taken.
   assign adv        = ~out_valid_o | out_ready_i;
   assign in_ready_o = adv;

   // Valid chain: reset drops every in-flight beat; otherwise bubbles and
   // beats march forward only on advance.
   always_ff @(posedge clk) begin
      if (rst) begin
         validS1 <= 1'b0;
         validS2 <= 1'b0;
         validS3 <= 1'b0;
      end else if (adv) begin
         validS1 <= in_valid_i;
         validS2 <= validS1;
         validS3 <= validS2;
      end
   end

   // S1: capture the beat. The multiplier operand 'a' is in2 for DIT or the
   // pre-subtracted in1-in2 for DIF; the pass-through term 'b' is in1 for
   // DIT or the pre-added in1+in2 for DIF, so S4 has one datapath for both.
   always_ff @(posedge clk) begin
      if (adv) begin
         modeS1  <= mode_dif_i;
         scaleS1 <= scale_i;
         wReS1   <= w_r_i;
         wImS1   <= w_i_i;
         if (mode_dif_i == MODE_DIF) begin
            aReS1 <= A_W'(in1_r_i) - A_W'(in2_r_i);
            aImS1 <= A_W'(in1_i_i) - A_W'(in2_i_i);
            bReS1 <= A_W'(in1_r_i) + A_W'(in2_r_i);
            bImS1 <= A_W'(in1_i_i) + A_W'(in2_i_i);
         end else begin
            aReS1 <= A_W'(in2_r_i);
            aImS1 <= A_W'(in2_i_i);
            bReS1 <= A_W'(in1_r_i);
            bImS1 <= A_W'(in1_i_i);
         end
      end
   end

   // S2-S3: complex multiply and round.
   cmul_pipe #(
      .A_WIDTH  (A_W),
      .TW_WIDTH (TW_WIDTH)
   ) uCmul (
      .clk    (clk),
      .enable (adv),
      .aRe    (aReS1),
      .aIm    (aImS1),
      .wRe    (wReS1),
      .wIm    (wImS1),
      .pRe    (pRe),
      .pIm    (pIm)
   );

   // Side-band and pass-through term ride alongside the multiplier.
   always_ff @(posedge clk) begin
      if (adv) begin
         modeS2  <= modeS1;
         modeS3  <= modeS2;
         scaleS2 <= scaleS1;
         scaleS3 <= scaleS2;
         bReS2   <= bReS1;
         bImS2   <= bImS1;
         bReS3   <= bReS2;
         bImS3   <= bImS2;
      end
   end

   // S4 combinational part: butterfly add/sub (DIT) or pass-through (DIF),
   // optional halving with round-half-up, then saturation to DATA_WIDTH.
   always_comb begin
      if (modeS3 == MODE_DIF) begin
         rawRes[0] = SUM_W'(bReS3);
         rawRes[1] = SUM_W'(bImS3);
         rawRes[2] = pRe;
         rawRes[3] = pIm;
      end else begin
         rawRes[0] = SUM_W'(bReS3) + pRe;
         rawRes[1] = SUM_W'(bImS3) + pIm;
         rawRes[2] = SUM_W'(bReS3) - pRe;
         rawRes[3] = SUM_W'(bImS3) - pIm;
      end
      for (int k = 0; k < 4; k++) begin
         scaledRes[k] = scaleS3 ? ((rawRes[k] + SUM_ONE) >>> 1) : rawRes[k];
         satRes[k]    = saturate(64'(scaledRes[k]), DATA_WIDTH);
      end
   end

   // Output registers. They only load with a real beat, so they keep their
   // value through bubbles and while backpressured.
   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid_o <= 1'b0;
         ovf_o       <= 1'b0;
         out1_r_o    <= '0;
         out1_i_o    <= '0;
         out2_r_o    <= '0;
         out2_i_o    <= '0;
      end else if (adv) begin
         out_valid_o <= validS3;
         if (validS3) begin
            out1_r_o <= satRes[0].value[DATA_WIDTH-1:0];
            out1_i_o <= satRes[1].value[DATA_WIDTH-1:0];
            out2_r_o <= satRes[2].value[DATA_WIDTH-1:0];
            out2_i_o <= satRes[3].value[DATA_WIDTH-1:0];
            ovf_o    <= satRes[0].clip | satRes[1].clip |
                        satRes[2].clip | satRes[3].clip;
         end
      end
   end

endmodule

// File: tb/tb_butterfly_r2_pipe.sv
// ---------------------------------------------------------------------------
// tb_butterfly_r2_pipe
// Scoreboard bench for butterfly_r2_pipe: the driver pushes the expected
// result of every accepted beat, an independent monitor pops and compares
// whenever an output beat is transferred.
// ---------------------------------------------------------------------------
module tb_butterfly_r2_pipe;
   import fft_pkg::*;

   localparam int DW = 16;
   localparam int TW = 16;

   logic                  clk = 1'b0;
   logic                  rst;
   logic                  in_valid_i;
   logic                  in_ready_o;
   logic                  mode_dif_i;
   logic                  scale_i;
   logic signed [DW-1:0]  in1_r_i, in1_i_i, in2_r_i, in2_i_i;
   logic signed [TW-1:0]  w_r_i, w_i_i;
   logic                  out_valid_o;
   logic                  out_ready_i;
   logic signed [DW-1:0]  out1_r_o, out1_i_o, out2_r_o, out2_i_o;
   logic                  ovf_o;

   typedef struct {
      longint val [4];
      bit     ovf;
      int     acceptT;
      bit     chkLat;
   } expect_t;

   expect_t sbQueue [$];
   int      checks = 0;
   int      failures = 0;
   int      cycle = 0;
   int      beatNo = 0;
   bit      randomReady = 1'b0;
   bit      heldPrev = 1'b0;
   longint  heldVal [5];

   butterfly_r2_pipe #(.DATA_WIDTH(DW), .TW_WIDTH(TW)) dut (
      .clk         (clk),
      .rst         (rst),
      .in_valid_i  (in_valid_i),
      .in_ready_o  (in_ready_o),
      .mode_dif_i  (mode_dif_i),
      .scale_i     (scale_i),
      .in1_r_i     (in1_r_i),
      .in1_i_i     (in1_i_i),
      .in2_r_i     (in2_r_i),
      .in2_i_i     (in2_i_i),
      .w_r_i       (w_r_i),
      .w_i_i       (w_i_i),
      .out_valid_o (out_valid_o),
      .out_ready_i (out_ready_i),
      .out1_r_o    (out1_r_o),
      .out1_i_o    (out1_i_o),
      .out2_r_o    (out2_r_o),
      .out2_i_o    (out2_i_o),
      .ovf_o       (ovf_o)
   );

   // Free-running clock and a cycle counter used for latency measurement.
   always #5 clk = ~clk;

   always @(posedge clk) cycle <= cycle + 1;

   // Downstream readiness: constant 1, or a coin flip each cycle.
   always @(posedge clk) begin
      #1;
      out_ready_i = randomReady ? 1'($urandom_range(0, 1)) : 1'b1;
   end

   // Hard stop in case something stalls beyond every bounded wait.
   initial begin
      #2000000;
      $display("[TB] FAIL watchdog actual=timeout required=finish");
      $fatal(1);
   end

   task automatic checkOutput(input string name, input longint actual, input longint expected);
      checks++;
      if (actual != expected) begin
         failures++;
         $display("[TB] FAIL %s actual=%0d required=%0d", name, actual, expected);
      end
   endtask

   // Reference model: plain integer arithmetic straight from the butterfly
   // definition (complex product, single round, optional halve, clip).
   function automatic longint rnd(input longint x);
      return (x + (longint'(1) <<< (TW - 3))) >>> (TW - 2);
   endfunction

   function automatic expect_t model(input longint a1r, a1i, a2r, a2i, wr, wi,
                                     input bit dif, input bit sc);
      expect_t e;
      longint  r [4];
      longint  dr, di, pr, pi, hi, lo;
      if (!dif) begin
         pr   = rnd(a2r * wr - a2i * wi);
         pi   = rnd(a2r * wi + a2i * wr);
         r[0] = a1r + pr;
         r[1] = a1i + pi;
         r[2] = a1r - pr;
         r[3] = a1i - pi;
      end else begin
         dr   = a1r - a2r;
         di   = a1i - a2i;
         r[0] = a1r + a2r;
         r[1] = a1i + a2i;
         r[2] = rnd(dr * wr - di * wi);
         r[3] = rnd(dr * wi + di * wr);
      end
      hi    = (longint'(1) <<< (DW - 1)) - 1;
      lo    = -hi - 1;
      e.ovf = 1'b0;
      for (int k = 0; k < 4; k++) begin
         if (sc) r[k] = (r[k] + 1) >>> 1;
         if (r[k] > hi) begin
            r[k]  = hi;
            e.ovf = 1'b1;
         end else if (r[k] < lo) begin
            r[k]  = lo;
            e.ovf = 1'b1;
         end
         e.val[k] = r[k];
      end
      e.acceptT = 0;
      e.chkLat  = 1'b0;
      return e;
   endfunction

   function automatic expect_t mkExp(input longint a, b, c, d, input bit ovf);
      expect_t e;
      e.val[0]  = a;
      e.val[1]  = b;
      e.val[2]  = c;
      e.val[3]  = d;
      e.ovf     = ovf;
      e.acceptT = 0;
      e.chkLat  = 1'b0;
      return e;
   endfunction

   // Present one beat and hold it until accepted; the expected result is
   // either the model's or a hand-computed one. Returns at posedge+1 with
   // in_valid_i still high so the next beat can follow without a bubble.
   task automatic applyStimulus(input int i1r, i1i, i2r, i2i, wr, wi,
                                input bit dif, input bit sc,
                                input bit useGiven, input expect_t given);
      expect_t e;
      int      tries;
      bit      done;
      in_valid_i = 1'b1;
      in1_r_i    = DW'(i1r);
      in1_i_i    = DW'(i1i);
      in2_r_i    = DW'(i2r);
      in2_i_i    = DW'(i2i);
      w_r_i      = TW'(wr);
      w_i_i      = TW'(wi);
      mode_dif_i = dif;
      scale_i    = sc;
      e = useGiven ? given : model(i1r, i1i, i2r, i2i, wr, wi, dif, sc);
      tries = 0;
      done  = 1'b0;
      while (!done) begin
         @(negedge clk);
         if (in_ready_o) begin
            e.acceptT = cycle;
            e.chkLat  = !randomReady;
            sbQueue.push_back(e);
            done = 1'b1;
         end else if (tries > 200) begin
            checks++;
            failures++;
            $display("[TB] FAIL acceptTimeout actual=not_ready required=ready");
            done = 1'b1;
         end
         tries++;
         @(posedge clk);
         #1;
      end
   endtask

   task automatic idle(input int n);
      in_valid_i = 1'b0;
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Monitor: handshake rule, hold stability under backpressure, and
   // in-order comparison of every transferred beat against the scoreboard.
   always @(negedge clk) begin
      expect_t e;
      if (rst) begin
         heldPrev = 1'b0;
      end else begin
         checkOutput("inReadyRule", longint'(in_ready_o), longint'(!out_valid_o || out_ready_i));
         if (heldPrev) begin
            checkOutput("heldValid", longint'(out_valid_o), 1);
            checkOutput("heldOut1R", longint'(out1_r_o), heldVal[0]);
            checkOutput("heldOut1I", longint'(out1_i_o), heldVal[1]);
            checkOutput("heldOut2R", longint'(out2_r_o), heldVal[2]);
            checkOutput("heldOut2I", longint'(out2_i_o), heldVal[3]);
            checkOutput("heldOvf",   longint'(ovf_o),    heldVal[4]);
         end
         if (out_valid_o && out_ready_i) begin
            if (sbQueue.size() == 0) begin
               checks++;
               failures++;
               $display("[TB] FAIL unexpectedBeat actual=out_valid required=no_beat");
            end else begin
               e = sbQueue.pop_front();
               checkOutput($sformatf("beat%0d_out1R", beatNo), longint'(out1_r_o), e.val[0]);
               checkOutput($sformatf("beat%0d_out1I", beatNo), longint'(out1_i_o), e.val[1]);
               checkOutput($sformatf("beat%0d_out2R", beatNo), longint'(out2_r_o), e.val[2]);
               checkOutput($sformatf("beat%0d_out2I", beatNo), longint'(out2_i_o), e.val[3]);
               checkOutput($sformatf("beat%0d_ovf",   beatNo), longint'(ovf_o),    longint'(e.ovf));
               if (e.chkLat)
                  checkOutput($sformatf("beat%0d_latency", beatNo), longint'(cycle - e.acceptT), 4);
            end
            beatNo++;
         end
         heldPrev   = out_valid_o && !out_ready_i;
         heldVal[0] = longint'(out1_r_o);
         heldVal[1] = longint'(out1_i_o);
         heldVal[2] = longint'(out2_r_o);
         heldVal[3] = longint'(out2_i_o);
         heldVal[4] = longint'(ovf_o);
      end
   end

   initial begin
      expect_t              none;
      int                   one;
      int                   waitCnt;
      logic signed [DW-1:0] rv [4];
      none = mkExp(0, 0, 0, 0, 1'b0);
      one  = TW_ONE(TW);

      rst         = 1'b1;
      in_valid_i  = 1'b0;
      mode_dif_i  = 1'b0;
      scale_i     = 1'b0;
      in1_r_i     = '0;
      in1_i_i     = '0;
      in2_r_i     = '0;
      in2_i_i     = '0;
      w_r_i       = '0;
      w_i_i       = '0;
      out_ready_i = 1'b1;

      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      checkOutput("rstOutValid", longint'(out_valid_o), 0);
      checkOutput("rstOvf",      longint'(ovf_o), 0);
      checkOutput("rstOut1R",    longint'(out1_r_o), 0);
      checkOutput("rstOut2I",    longint'(out2_i_o), 0);
      checkOutput("rstInReady",  longint'(in_ready_o), 1);
      @(posedge clk);
      #1;

      $display("[TB] directed beats");
      applyStimulus(1000, 200, 300, -100, one, 0, 1'b0, 1'b0, 1'b1, mkExp(1300, 100, 700, 300, 1'b0));
      idle(1);
      applyStimulus(1000, 200, 300, -100, 0, -one, 1'b0, 1'b0, 1'b1, mkExp(900, -100, 1100, 500, 1'b0));
      applyStimulus(1000, 200, 300, -100, 0, -one, 1'b0, 1'b1, 1'b1, mkExp(450, -50, 550, 250, 1'b0));
      applyStimulus(1000, 200, 300, -100, 0, -one, 1'b1, 1'b0, 1'b1, mkExp(1300, 100, 300, -700, 1'b0));
      for (int i = 0; i < 4; i++) begin
         if (i % 2 == 0)
            applyStimulus(1000, 200, 300, -100, 0, -one, 1'b0, 1'b0, 1'b1, mkExp(900, -100, 1100, 500, 1'b0));
         else
            applyStimulus(1000, 200, 300, -100, 0, -one, 1'b1, 1'b0, 1'b1, mkExp(1300, 100, 300, -700, 1'b0));
      end
      applyStimulus(0, 0, 3, -3, one / 2, 0, 1'b0, 1'b0, 1'b1, mkExp(2, -1, -2, 1, 1'b0));
      applyStimulus(32767, -32768, 32767, -32768, one, 0, 1'b0, 1'b0, 1'b1,
                    mkExp(32767, -32768, 0, 0, 1'b1));
      applyStimulus(32767, -32768, 32767, -32768, one, 0, 1'b0, 1'b1, 1'b1,
                    mkExp(32767, -32768, 0, 0, 1'b0));
      idle(8);

      $display("[TB] random beats with backpressure");
      randomReady = 1'b1;
      for (int i = 0; i < 40; i++) begin
         if ($urandom_range(0, 3) == 0) idle(1);
         for (int k = 0; k < 4; k++) rv[k] = DW'($urandom);
         applyStimulus(int'(rv[0]), int'(rv[1]), int'(rv[2]), int'(rv[3]),
                       int'($urandom_range(0, 2 * one)) - one,
                       int'($urandom_range(0, 2 * one)) - one,
                       1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0, none);
      end
      in_valid_i  = 1'b0;
      randomReady = 1'b0;
      waitCnt = 0;
      while (sbQueue.size() != 0 && waitCnt < 300) begin
         @(posedge clk);
         waitCnt++;
      end
      checkOutput("drainPending", longint'(sbQueue.size()), 0);
      idle(3);

      $display("[TB] reset with beats in flight");
      applyStimulus(100, 200, 300, 400, one, 0, 1'b0, 1'b0, 1'b0, none);
      applyStimulus(-100, 50, 7, 9, 0, one, 1'b1, 1'b0, 1'b0, none);
      applyStimulus(5, 6, 7, 8, one, one, 1'b0, 1'b1, 1'b0, none);
      in_valid_i = 1'b0;
      rst        = 1'b1;
      sbQueue.delete();
      @(posedge clk);
      #1;
      rst = 1'b0;
      checkOutput("midRstOutValid", longint'(out_valid_o), 0);
      checkOutput("midRstOvf",      longint'(ovf_o), 0);
      checkOutput("midRstOut1R",    longint'(out1_r_o), 0);
      checkOutput("midRstInReady",  longint'(in_ready_o), 1);
      idle(12);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
